// File: rtl/alu_exc_wb_stage.sv
// alu_exc_wb_stage: register stage directly after the ALU.
// - Registers the ALU result, zero flag and destination into the writeback path (1-cycle latency).
// - Converts a trapping signed overflow into a precise exception: the faulting instruction is
//   squashed, EPC/Cause are captured, and fetch is redirected to VECTOR, then back to EPC on eret.
// - Optional external interrupt entry, enabled by defining the macro EXT_INT_EN (adds int_req).
module alu_exc_wb_stage #(
    parameter logic [31:0] VECTOR  = 32'h0000_0004,
    parameter logic [4:0]  EXC_OVF = 5'd12
`ifdef EXT_INT_EN
    ,
    parameter logic [4:0]  EXC_INT = 5'd0
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_res,
    input  logic        ex_zero,
    input  logic        ex_overflow,
    input  logic        ex_ovf_trap,
    input  logic        ex_eret,
    input  logic        ex_wr_en,
    input  logic [4:0]  ex_wr_addr,
`ifdef EXT_INT_EN
    input  logic        int_req,
`endif
    output logic        wb_valid,
    output logic [4:0]  wb_wr_addr,
    output logic [31:0] wb_data,
    output logic        wb_zero,
    output logic        exc_redirect,
    output logic [31:0] exc_target,
    output logic [31:0] epc,
    output logic [31:0] cause,
    output logic        in_handler
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        TRAP    = 2'd1,
        HANDLER = 2'd2,
        RET     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_wb_valid;
    logic [4:0]  r_wb_wr_addr;
    logic [31:0] r_wb_data;
    logic        r_wb_zero;
    logic [31:0] r_epc;
    logic [4:0]  r_cause_code;
    logic        r_ovf_lost;

    logic        w_take;
    logic        w_wb_open;
    logic        w_wb_next;

    // eret has priority over overflow, so an eret never traps.
    assign w_take    = ex_valid & ex_overflow & ex_ovf_trap & ~ex_eret;
    // TRAP and RET cycles hold the instruction being flushed; it must not write back.
    assign w_wb_open = (r_state == RUN) || (r_state == HANDLER);
    assign w_wb_next = ex_valid & ex_wr_en & ~w_take & ~ex_eret & w_wb_open;

`ifdef EXT_INT_EN
    logic        w_int_take;
    // Interrupt is taken after the EX instruction completes; overflow wins and the level stays pending.
    assign w_int_take = (r_state == RUN) & ex_valid & int_req & ~w_take & ~ex_eret;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            RUN: begin
                if (w_take) begin
                    w_state_next = TRAP;
                end
`ifdef EXT_INT_EN
                else if (w_int_take) begin
                    w_state_next = TRAP;
                end
`endif
            end
            TRAP:    w_state_next = HANDLER;
            HANDLER: begin
                if (ex_valid && ex_eret) begin
                    w_state_next = RET;
                end
            end
            RET:     w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    // Redirect and status outputs decoded from the current state.
    always_comb begin
        exc_redirect = 1'b0;
        exc_target   = 32'h0;
        in_handler   = 1'b0;
        unique case (r_state)
            TRAP: begin
                exc_redirect = 1'b1;
                exc_target   = VECTOR;
            end
            RET: begin
                exc_redirect = 1'b1;
                exc_target   = r_epc;
            end
            HANDLER: in_handler = 1'b1;
            default: ;
        endcase
    end

    // Writeback registers: the payload only moves when a writeback is issued, otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid   <= 1'b0;
            r_wb_wr_addr <= 5'd0;
            r_wb_data    <= 32'h0;
            r_wb_zero    <= 1'b0;
        end else begin
            r_wb_valid <= w_wb_next;
            if (w_wb_next) begin
                r_wb_wr_addr <= ex_wr_addr;
                r_wb_data    <= ex_res;
                r_wb_zero    <= ex_zero;
            end
        end
    end

    // Exception status: EPC and cause code captured on entry; OVF_LOST is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc        <= 32'h0;
            r_cause_code <= 5'd0;
            r_ovf_lost   <= 1'b0;
        end else begin
            if ((r_state == RUN) && w_take) begin
                r_epc        <= ex_pc;
                r_cause_code <= EXC_OVF;
            end
`ifdef EXT_INT_EN
            else if (w_int_take) begin
                // Interrupted instruction completed, so resume after it.
                r_epc        <= ex_pc + 32'd4;
                r_cause_code <= EXC_INT;
            end
`endif
            // A nested overflow cannot trap (EPC would be clobbered); record that it was dropped.
            if ((r_state == HANDLER) && w_take) begin
                r_ovf_lost <= 1'b1;
            end
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_wr_addr = r_wb_wr_addr;
    assign wb_data    = r_wb_data;
    assign wb_zero    = r_wb_zero;
    assign epc        = r_epc;
    assign cause      = {25'h0, r_cause_code, r_ovf_lost, 1'b0};

endmodule

// File: tb/tb_alu_exc_wb_stage.sv
// tb_alu_exc_wb_stage: directed vector table for single-cycle behaviour in RUN, plus hand-written
// sequences for trap entry, nested overflow in the handler, eret return and reset during TRAP.
// Inputs change on the falling edge; outputs are compared on the following falling edge.
module tb_alu_exc_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic [31:0] ex_res = 32'h0;
    logic        ex_zero = 1'b0;
    logic        ex_overflow = 1'b0;
    logic        ex_ovf_trap = 1'b0;
    logic        ex_eret = 1'b0;
    logic        ex_wr_en = 1'b0;
    logic [4:0]  ex_wr_addr = 5'd0;
`ifdef EXT_INT_EN
    logic        int_req = 1'b0;
`endif
    logic        wb_valid;
    logic [4:0]  wb_wr_addr;
    logic [31:0] wb_data;
    logic        wb_zero;
    logic        exc_redirect;
    logic [31:0] exc_target;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        in_handler;

    int n_checks = 0;
    int n_errors = 0;

    alu_exc_wb_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_res       (ex_res),
        .ex_zero      (ex_zero),
        .ex_overflow  (ex_overflow),
        .ex_ovf_trap  (ex_ovf_trap),
        .ex_eret      (ex_eret),
        .ex_wr_en     (ex_wr_en),
        .ex_wr_addr   (ex_wr_addr),
`ifdef EXT_INT_EN
        .int_req      (int_req),
`endif
        .wb_valid     (wb_valid),
        .wb_wr_addr   (wb_wr_addr),
        .wb_data      (wb_data),
        .wb_zero      (wb_zero),
        .exc_redirect (exc_redirect),
        .exc_target   (exc_target),
        .epc          (epc),
        .cause        (cause),
        .in_handler   (in_handler)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        trap;
        logic        eret;
        logic        wr;
        logic [4:0]  addr;
        logic        exp_wbv;
        logic [31:0] exp_data;
        logic [4:0]  exp_addr;
        logic        exp_zero;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] res,
                          input logic z, input logic ovf, input logic trap, input logic eret,
                          input logic wr, input logic [4:0] addr);
        ex_valid    = v;
        ex_pc       = pc;
        ex_res      = res;
        ex_zero     = z;
        ex_overflow = ovf;
        ex_ovf_trap = trap;
        ex_eret     = eret;
        ex_wr_en    = wr;
        ex_wr_addr  = addr;
    endtask

    task automatic idle();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        // valid pc res zero ovf trap eret wr addr | wbv data addr zero
        vecs[0] = '{1'b1, 32'h10, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,
                    1'b1, 32'hFFFF_FFFF, 5'd3, 1'b0};
        vecs[1] = '{1'b1, 32'h14, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7,
                    1'b1, 32'h0000_0000, 5'd7, 1'b1};
        // no register write: payload holds
        vecs[2] = '{1'b1, 32'h18, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9,
                    1'b0, 32'h0000_0000, 5'd7, 1'b1};
        // bubble: payload holds
        vecs[3] = '{1'b0, 32'h1C, 32'h0000_5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1,
                    1'b0, 32'h0000_0000, 5'd7, 1'b1};
        // overflow on an unsigned form: plain writeback, no trap
        vecs[4] = '{1'b1, 32'h40, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4,
                    1'b1, 32'h8000_0000, 5'd4, 1'b0};
        // eret in RUN: nothing happens
        vecs[5] = '{1'b1, 32'h44, 32'h0000_AAAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,
                    1'b0, 32'h8000_0000, 5'd4, 1'b0};
        // eret with trapping overflow: eret wins, overflow ignored
        vecs[6] = '{1'b1, 32'h48, 32'h0000_BBBB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6,
                    1'b0, 32'h8000_0000, 5'd4, 1'b0};
        vecs[7] = '{1'b1, 32'h4C, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd31,
                    1'b1, 32'h7FFF_FFFF, 5'd31, 1'b0};

        // Reset state
        #12;
        check("rst wb_valid", {31'h0, wb_valid}, 32'h0);
        check("rst wb_data", wb_data, 32'h0);
        check("rst redirect", {31'h0, exc_redirect}, 32'h0);
        check("rst epc", epc, 32'h0);
        check("rst cause", cause, 32'h0);
        check("rst in_handler", {31'h0, in_handler}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single-cycle behaviour in RUN
        for (int i = 0; i < 8; i++) begin
            set_ex(vecs[i].valid, vecs[i].pc, vecs[i].res, vecs[i].zero, vecs[i].ovf,
                   vecs[i].trap, vecs[i].eret, vecs[i].wr, vecs[i].addr);
            tick();
            check($sformatf("vec%0d wb_valid", i), {31'h0, wb_valid}, {31'h0, vecs[i].exp_wbv});
            check($sformatf("vec%0d wb_data", i), wb_data, vecs[i].exp_data);
            check($sformatf("vec%0d wb_wr_addr", i), {27'h0, wb_wr_addr}, {27'h0, vecs[i].exp_addr});
            check($sformatf("vec%0d wb_zero", i), {31'h0, wb_zero}, {31'h0, vecs[i].exp_zero});
            check($sformatf("vec%0d redirect", i), {31'h0, exc_redirect}, 32'h0);
            check($sformatf("vec%0d cause", i), cause, 32'h0);
            check($sformatf("vec%0d epc", i), epc, 32'h0);
        end

        // Trap entry: overflowing add at 0x40
        set_ex(1'b1, 32'h40, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2);
        tick();
        check("trap wb_valid", {31'h0, wb_valid}, 32'h0);
        check("trap wb_data hold", wb_data, 32'h7FFF_FFFF);
        check("trap redirect", {31'h0, exc_redirect}, 32'h1);
        check("trap target", exc_target, 32'h4);
        check("trap epc", epc, 32'h40);
        check("trap cause", cause, 32'h30);
        check("trap in_handler", {31'h0, in_handler}, 32'h0);
        // Instruction in EX during TRAP is flushed and must not write back
        set_ex(1'b1, 32'h44, 32'h0000_DEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
        tick();
        check("hdl in_handler", {31'h0, in_handler}, 32'h1);
        check("hdl redirect", {31'h0, exc_redirect}, 32'h0);
        check("hdl flushed wb_valid", {31'h0, wb_valid}, 32'h0);

        // Normal writeback inside the handler
        set_ex(1'b1, 32'h4, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
        tick();
        check("hdl wb_valid", {31'h0, wb_valid}, 32'h1);
        check("hdl wb_data", wb_data, 32'h11);

        // Nested overflow: dropped and recorded
        set_ex(1'b1, 32'h100, 32'h8000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9);
        tick();
        check("nest wb_valid", {31'h0, wb_valid}, 32'h0);
        check("nest redirect", {31'h0, exc_redirect}, 32'h0);
        check("nest cause", cause, 32'h32);
        check("nest epc", epc, 32'h40);
        check("nest in_handler", {31'h0, in_handler}, 32'h1);

        // eret returns to EPC
        set_ex(1'b1, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        tick();
        check("ret redirect", {31'h0, exc_redirect}, 32'h1);
        check("ret target", exc_target, 32'h40);
        check("ret in_handler", {31'h0, in_handler}, 32'h0);
        check("ret wb_valid", {31'h0, wb_valid}, 32'h0);
        set_ex(1'b1, 32'hC, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10);
        tick();
        check("ret1 redirect", {31'h0, exc_redirect}, 32'h0);
        check("ret1 flushed wb_valid", {31'h0, wb_valid}, 32'h0);
        set_ex(1'b1, 32'h40, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11);
        tick();
        check("run wb_valid", {31'h0, wb_valid}, 32'h1);
        check("run wb_data", wb_data, 32'h33);
        check("run epc kept", epc, 32'h40);
        check("run cause kept", cause, 32'h32);

        // Reset asserted during TRAP
        set_ex(1'b1, 32'h200, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd12);
        tick();
        check("t2 redirect", {31'h0, exc_redirect}, 32'h1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst redirect", {31'h0, exc_redirect}, 32'h0);
        check("mid rst target", exc_target, 32'h0);
        check("mid rst epc", epc, 32'h0);
        check("mid rst cause", cause, 32'h0);
        check("mid rst wb_data", wb_data, 32'h0);
        check("mid rst wb_valid", {31'h0, wb_valid}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post rst redirect", {31'h0, exc_redirect}, 32'h0);
        check("post rst in_handler", {31'h0, in_handler}, 32'h0);
        // Back in RUN: a fresh trap is taken and OVF_LOST is clear
        set_ex(1'b1, 32'h300, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd12);
        tick();
        check("t3 redirect", {31'h0, exc_redirect}, 32'h1);
        check("t3 epc", epc, 32'h300);
        check("t3 cause", cause, 32'h30);
        idle();
        tick();
        check("t3 in_handler", {31'h0, in_handler}, 32'h1);
        set_ex(1'b1, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        tick();
        check("t3 ret target", exc_target, 32'h300);
        idle();
        tick();
        check("t3 run redirect", {31'h0, exc_redirect}, 32'h0);

`ifdef EXT_INT_EN
        // External interrupt: EX instruction completes, EPC points past it
        int_req = 1'b1;
        set_ex(1'b1, 32'h80, 32'h0000_0099, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10);
        tick();
        int_req = 1'b0;
        idle();
        check("int wb_valid", {31'h0, wb_valid}, 32'h1);
        check("int wb_data", wb_data, 32'h99);
        check("int epc", epc, 32'h84);
        check("int cause", cause, 32'h0);
        check("int redirect", {31'h0, exc_redirect}, 32'h1);
        check("int target", exc_target, 32'h4);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
